// File: rtl/bp_update_ctrl_if.sv
// rtl/bp_update_ctrl_if.sv - pipeline-side bundle for the branch predictor update sequencer
interface bp_update_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              rdy;
  logic              fetch_br_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_pre_taken;
  logic              fetch_stall_o;
  logic              ex_br_valid;
  logic              ex_taken;
  logic              ex_stall_o;
  logic              flush_i;
  logic              mispredict_o;
  logic              upd_we_o;
  logic [ADDR_W-1:0] upd_waddr_o;
  logic              upd_res_taken_o;
  logic              upd_com_taken_o;
  logic              err_o;
  logic [31:0]       stat_branches_o;
  logic [31:0]       stat_mispred_o;

  modport master (
    output rdy, fetch_br_valid, fetch_pc, fetch_pre_taken, ex_br_valid, ex_taken, flush_i,
    input  fetch_stall_o, ex_stall_o, mispredict_o, upd_we_o, upd_waddr_o,
           upd_res_taken_o, upd_com_taken_o, err_o, stat_branches_o, stat_mispred_o
  );

  modport slave (
    input  rdy, fetch_br_valid, fetch_pc, fetch_pre_taken, ex_br_valid, ex_taken, flush_i,
    output fetch_stall_o, ex_stall_o, mispredict_o, upd_we_o, upd_waddr_o,
           upd_res_taken_o, upd_com_taken_o, err_o, stat_branches_o, stat_mispred_o
  );
endinterface

// File: rtl/bp_update_ctrl.sv
// rtl/bp_update_ctrl.sv - in-flight prediction queue and update FIFO feeding the predictor training port
module bp_update_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int IF_DEPTH  = 4,
  parameter int UPD_DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  bp_update_ctrl_if.slave bus
);
  localparam int IW = $clog2(IF_DEPTH);
  localparam int UW = $clog2(UPD_DEPTH);
  localparam logic [IW:0] IF_FULL  = (IW+1)'(IF_DEPTH);
  localparam logic [UW:0] UPD_FULL = (UW+1)'(UPD_DEPTH);

  // in-flight prediction queue
  logic [ADDR_W-1:0] r_if_pc  [IF_DEPTH];
  logic              r_if_pre [IF_DEPTH];
  logic [IW-1:0]     r_if_head;
  logic [IW-1:0]     r_if_tail;
  logic [IW:0]       r_if_cnt;

  // pending-update FIFO, entries are {pc, res_taken, com_taken}
  logic [ADDR_W+1:0] r_up_mem [UPD_DEPTH];
  logic [UW-1:0]     r_up_head;
  logic [UW-1:0]     r_up_tail;
  logic [UW:0]       r_up_cnt;

  logic              r_mispredict;
  logic              r_upd_we;
  logic [ADDR_W-1:0] r_upd_waddr;
  logic              r_upd_res;
  logic              r_upd_com;
  logic              r_err;
  logic [31:0]       r_stat_br;
  logic [31:0]       r_stat_mp;

  logic              w_fetch_stall;
  logic              w_ex_stall;
  logic              w_if_empty;
  logic [ADDR_W-1:0] w_head_pc;
  logic              w_head_pre;
  logic              w_pop;
  logic              w_mis;
  logic              w_clear;
  logic              w_push;
  logic              w_err_ev;
  logic              w_drain;

  assign w_fetch_stall = (r_if_cnt == IF_FULL);
  assign w_ex_stall    = (r_up_cnt == UPD_FULL);
  assign w_if_empty    = (r_if_cnt == '0);
  assign w_head_pc     = r_if_pc[r_if_head];
  assign w_head_pre    = r_if_pre[r_if_head];
  // a resolve waits (is ignored) while the update FIFO is full; EX keeps requesting
  assign w_pop         = bus.rdy & bus.ex_br_valid & ~w_if_empty & ~w_ex_stall;
  assign w_mis         = w_pop & (bus.ex_taken != w_head_pre);
  // after a mispredict everything younger than the head is wrong-path
  assign w_clear       = bus.rdy & (w_mis | bus.flush_i);
  assign w_push        = bus.rdy & bus.fetch_br_valid & ~w_fetch_stall & ~w_mis & ~bus.flush_i;
  assign w_err_ev      = bus.rdy & bus.ex_br_valid & w_if_empty;
  assign w_drain       = bus.rdy & (r_up_cnt != '0);

  assign bus.fetch_stall_o   = w_fetch_stall;
  assign bus.ex_stall_o      = w_ex_stall;
  assign bus.mispredict_o    = r_mispredict;
  assign bus.upd_we_o        = r_upd_we;
  assign bus.upd_waddr_o     = r_upd_waddr;
  assign bus.upd_res_taken_o = r_upd_res;
  assign bus.upd_com_taken_o = r_upd_com;
  assign bus.err_o           = r_err;
  assign bus.stat_branches_o = r_stat_br;
  assign bus.stat_mispred_o  = r_stat_mp;

  // in-flight storage write on accepted fetch
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_if_pc[r_if_tail]  <= bus.fetch_pc;
      r_if_pre[r_if_tail] <= bus.fetch_pre_taken;
    end
  end

  // in-flight pointers and occupancy; a clear collapses the queue onto the post-pop head
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_head <= '0;
      r_if_tail <= '0;
      r_if_cnt  <= '0;
    end else if (bus.rdy) begin
      r_if_head <= r_if_head + IW'(w_pop);
      if (w_clear) begin
        r_if_tail <= r_if_head + IW'(w_pop);
        r_if_cnt  <= '0;
      end else begin
        r_if_tail <= r_if_tail + IW'(w_push);
        r_if_cnt  <= r_if_cnt + (IW+1)'(w_push) - (IW+1)'(w_pop);
      end
    end
  end

  // update FIFO storage write on every resolved branch
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_up_mem[r_up_tail] <= {w_head_pc, bus.ex_taken, w_head_pre};
    end
  end

  // update FIFO pointers; flushes and mispredicts never touch it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_up_head <= '0;
      r_up_tail <= '0;
      r_up_cnt  <= '0;
    end else begin
      r_up_head <= r_up_head + UW'(w_drain);
      r_up_tail <= r_up_tail + UW'(w_pop);
      r_up_cnt  <= r_up_cnt + (UW+1)'(w_pop) - (UW+1)'(w_drain);
    end
  end

  // registered outputs: training port, mispredict pulse, sticky error and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mispredict <= 1'b0;
      r_upd_we     <= 1'b0;
      r_upd_waddr  <= '0;
      r_upd_res    <= 1'b0;
      r_upd_com    <= 1'b0;
      r_err        <= 1'b0;
      r_stat_br    <= '0;
      r_stat_mp    <= '0;
    end else if (bus.rdy) begin
      r_mispredict <= w_mis;
      r_upd_we     <= w_drain;
      if (w_drain) begin
        {r_upd_waddr, r_upd_res, r_upd_com} <= r_up_mem[r_up_head];
      end
      if (w_err_ev) begin
        r_err <= 1'b1;
      end
      if (w_pop) begin
        r_stat_br <= r_stat_br + 32'd1;
      end
      if (w_mis) begin
        r_stat_mp <= r_stat_mp + 32'd1;
      end
    end else begin
      // a stalled cycle must not present a second write of the same entry
      r_upd_we <= 1'b0;
    end
  end
endmodule
